// File: rtl/aes_pkg.sv
// Shared AES inverse-round definitions: byte indexing, GF(2^8) constant multipliers, FSM states.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Column-major state layout: byte k = 4*col + row.
  function automatic int idx(input int row, input int col);
    return 4 * col + row;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul09(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ a;
  endfunction

  function automatic logic [7:0] gf_mul0b(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x2 ^ a;
  endfunction

  function automatic logic [7:0] gf_mul0d(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ a;
  endfunction

  function automatic logic [7:0] gf_mul0e(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

endpackage

// File: rtl/aes_inv_mix_column.sv
// Combinational InvMixColumns of one 32-bit column; row 0 sits in bits [31:24].
module aes_inv_mix_column
  import aes_pkg::*;
(
  input  logic [31:0] i_col,
  output logic [31:0] o_col
);

  logic [7:0] w_a [4];

  for (genvar r = 0; r < 4; r++) begin : g_row
    assign w_a[r] = i_col[31-8*r -: 8];
    assign o_col[31-8*r -: 8] = gf_mul0e(w_a[r])
                              ^ gf_mul0b(w_a[(r+1)%4])
                              ^ gf_mul0d(w_a[(r+2)%4])
                              ^ gf_mul09(w_a[(r+3)%4]);
  end

endmodule

// File: rtl/aes_inv_round_unit.sv
// Inverse AES round: InvMixColumns(InvShiftRows(state) ^ key), mixed column-serially.
// Byte k of a 128-bit bus lives in bits [127-8k -: 8] (byte 0 leftmost in a hex literal).
module aes_inv_round_unit
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic [127:0] in_rkey,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("aes_inv_round_unit: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

  state_t       r_state;
  logic [1:0]   r_col;
  logic [127:0] r_work;
  logic         r_out_valid;

  logic [127:0] w_ark;
  logic [127:0] w_work_nxt;
  logic [COLS_PER_CYCLE-1:0][1:0]  w_sel;
  logic [COLS_PER_CYCLE-1:0][31:0] w_mix_in;
  logic [COLS_PER_CYCLE-1:0][31:0] w_mix_out;

  // Input network: row r of the output column c comes from column (c-r) mod 4; key is unshifted.
  for (genvar c = 0; c < 4; c++) begin : g_isr_col
    for (genvar r = 0; r < 4; r++) begin : g_isr_row
      localparam int D = idx(r, c);
      localparam int S = idx(r, (c - r + 4) % 4);
      assign w_ark[127-8*D -: 8] = in_state[127-8*S -: 8] ^ in_rkey[127-8*D -: 8];
    end
  end

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_lane
    assign w_sel[g]    = r_col + 2'(g);
    assign w_mix_in[g] = r_work[127-32*int'(w_sel[g]) -: 32];
    aes_inv_mix_column u_mix (
      .i_col (w_mix_in[g]),
      .o_col (w_mix_out[g])
    );
  end

  always_comb begin
    w_work_nxt = r_work;
    for (int g = 0; g < COLS_PER_CYCLE; g++)
      w_work_nxt[127-32*int'(w_sel[g]) -: 32] = w_mix_out[g];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_col       <= 2'd0;
      r_work      <= '0;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_work <= w_ark;
            r_col  <= 2'd0;
            if (in_last) begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          r_work <= w_work_nxt;
          r_col  <= r_col + 2'(COLS_PER_CYCLE);
          if (r_col == LAST_COL) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE) && !rst;
  assign out_valid = r_out_valid;
  assign out_state = r_work;

endmodule

// File: tb/tb_aes_inv_round_unit.sv
// Self-checking bench: three unit widths (1/2/4 columns per cycle), scoreboard on the 1-column unit.
module tb_aes_inv_round_unit;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [2:0]            iv, ordy, ir, ov;
  logic [127:0]          st, key;
  logic                  last;
  logic [2:0][127:0]     os;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_inv_round_unit #(.COLS_PER_CYCLE(1 << g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv[g]),
      .in_ready  (ir[g]),
      .in_state  (st),
      .in_rkey   (key),
      .in_last   (last),
      .out_valid (ov[g]),
      .out_ready (ordy[g]),
      .out_state (os[g])
    );
  end

  // Reference model: plain GF(2^8) multiply and a byte-array view of the state.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] p;
    logic [15:0] acc;
    acc = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) acc = acc ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (acc[i]) acc = acc ^ (16'h011b << (i - 8));
    p = acc[8:0];
    return p[7:0];
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input logic [127:0] k,
                                         input logic l);
    logic [7:0] sb [16];
    logic [7:0] t  [16];
    logic [7:0] o  [16];
    logic [7:0] coef [4];
    logic [127:0] res;
    coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    for (int b = 0; b < 16; b++) sb[b] = s[127-8*b -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[4*c+r] = sb[4*((c - r + 4) % 4) + r] ^ k[127-8*(4*c+r) -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        o[4*c+r] = 8'h00;
        for (int j = 0; j < 4; j++) o[4*c+r] ^= gmul(coef[j], t[4*c + (r + j) % 4]);
      end
    for (int b = 0; b < 16; b++) res[127-8*b -: 8] = l ? t[b] : o[b];
    return res;
  endfunction

  task automatic chk(input bit ok, input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard on unit 0: model result pushed on accept, compared on every output transfer,
  // and the held output must not move while out_ready is low.
  logic [127:0] q[$];
  int           nacc = 0;
  int           ndone = 0;
  logic         hold_v = 1'b0;
  logic [127:0] hold_s;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      nacc   = ndone;
      hold_v = 1'b0;
    end else begin
      if (hold_v) chk(ov[0] && os[0] == hold_s, "sb stable", os[0], hold_s);
      if (ov[0] && ordy[0]) begin
        if (q.size() == 0) chk(1'b0, "sb duplicate", os[0], 128'h0);
        else begin
          chk(os[0] == q[0], "sb data", os[0], q[0]);
          void'(q.pop_front());
          ndone++;
        end
      end
      hold_v = ov[0] && !ordy[0];
      hold_s = os[0];
      if (iv[0] && ir[0]) begin
        q.push_back(model(st, key, last));
        nacc++;
      end
    end
  end

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic xact(input int w, input logic [127:0] s, input logic [127:0] k, input bit l,
                      input int exp_lat, input logic [127:0] exp, input int hold,
                      input string nm);
    int lat;
    @(posedge clk); #1;
    iv[w] = 1'b1; st = s; key = k; last = l; ordy[w] = 1'b0;
    @(negedge clk);
    chk(ir[w] == 1'b1, {nm, " ready"}, 128'(ir[w]), 128'h1);
    @(posedge clk); #1;
    iv[w] = 1'b0; st = rnd128(); key = rnd128(); last = 1'($urandom);
    lat = 0;
    while (!ov[w] && lat < 16) begin
      @(posedge clk); #1;
      lat++;
    end
    chk(lat == exp_lat, {nm, " latency"}, 128'(lat), 128'(exp_lat));
    chk(os[w] == exp, nm, os[w], exp);
    for (int i = 0; i < hold; i++) begin
      iv[w] = 1'($urandom); st = rnd128(); key = rnd128();
      @(negedge clk);
      chk(ov[w] && !ir[w] && os[w] == exp, {nm, " hold"}, os[w], exp);
      @(posedge clk); #1;
    end
    iv[w] = 1'b0; ordy[w] = 1'b1;
    @(posedge clk); #1;
    ordy[w] = 1'b0;
    chk(!ov[w] && ir[w], {nm, " release"}, 128'({ov[w], ir[w]}), 128'h1);
  endtask

  localparam logic [127:0] T1_IN  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] T1_OUT = 128'h000d0a0704010e0b0805020f0c090603;
  localparam logic [127:0] C_A    = {4{32'h8e4da1bc}};
  localparam logic [127:0] C_A_O  = {4{32'hdb135345}};
  localparam logic [127:0] C_B    = {4{32'h9fdc589d}};
  localparam logic [127:0] C_B_O  = {4{32'hf20a225c}};

  initial begin
    logic [127:0] rs, rk;
    int           nsent;
    bit           acc;
    iv = '0; ordy = '0; st = '0; key = '0; last = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int w = 0; w < 3; w++)
      chk(!ov[w] && !ir[w] && os[w] == 128'h0, "reset state", os[w], 128'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk(ir == 3'b111, "ready after reset", 128'(ir), 128'h7);

    // Hand-computed values pin the model itself.
    chk(model(T1_IN, 128'h0, 1'b1) == T1_OUT, "model isr", model(T1_IN, 128'h0, 1'b1), T1_OUT);
    chk(model(C_A, 128'h0, 1'b0) == C_A_O, "model mix", model(C_A, 128'h0, 1'b0), C_A_O);

    xact(0, T1_IN, 128'h0, 1'b1, 0, T1_OUT, 0, "isr last");
    xact(0, 128'h0, T1_IN, 1'b1, 0, T1_IN, 0, "key unshifted");
    xact(0, C_A, 128'h0, 1'b0, 4, C_A_O, 0, "mix A n4");
    xact(0, C_B, 128'h0, 1'b0, 4, C_B_O, 0, "mix B n4");
    xact(1, C_A, 128'h0, 1'b0, 2, C_A_O, 0, "mix A n2");
    xact(1, C_B, 128'h0, 1'b0, 2, C_B_O, 0, "mix B n2");
    xact(2, C_A, 128'h0, 1'b0, 1, C_A_O, 0, "mix A n1");
    xact(2, C_B, 128'h0, 1'b0, 1, C_B_O, 0, "mix B n1");
    xact(1, T1_IN, 128'h0, 1'b1, 0, T1_OUT, 0, "isr last n2");

    rs = rnd128(); rk = rnd128();
    xact(0, rs, rk, 1'b0, 4, model(rs, rk, 1'b0), 10, "done hold");

    // Abort mid-RUN at column 2.
    @(posedge clk); #1;
    iv[0] = 1'b1; st = rnd128(); key = rnd128(); last = 1'b0; ordy[0] = 1'b0;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk(!ov[0] && ir[0], "abort flags", 128'({ov[0], ir[0]}), 128'h1);
    chk(os[0] == 128'h0, "abort state", os[0], 128'h0);
    rs = rnd128(); rk = rnd128();
    xact(0, rs, rk, 1'b0, 4, model(rs, rk, 1'b0), 0, "after abort");

    // Random back-to-back traffic with random backpressure on unit 0.
    nsent = 0;
    for (int cyc = 0; cyc < 4000 && nsent < 150; cyc++) begin
      @(negedge clk);
      acc = iv[0] && ir[0];
      @(posedge clk); #1;
      if (acc) nsent++;
      if (acc || !iv[0]) begin
        iv[0] = (nsent < 150) && ($urandom_range(3) != 0);
        st = rnd128(); key = rnd128(); last = ($urandom_range(3) == 0);
      end
      ordy[0] = ($urandom_range(2) != 0);
    end
    iv[0] = 1'b0; ordy[0] = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk(nsent == 150, "random sent", 128'(nsent), 128'd150);
    chk(q.size() == 0 && ndone == nacc, "no drops", 128'(ndone), 128'(nacc));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
